stopwatch_core: RTL and testbench

Timekeeping core of the stopwatch: consumes the single-cycle enable pulses from the clock divider (1 Hz, 2 Hz, 4 Hz) and maintains an MM:SS BCD count with pause and per-field adjust. Sits between the divider/debouncers and the seven-segment display driver. Outputs are BCD digits plus per-field blank flags for adjust-mode blinking.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_core_bcd_mod60.sv | 41 ++++
 rtl/stopwatch_core.sv | 143 ++++++++++++++
 tb/tb_stopwatch_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch timekeeping core: BCD digit width,
//   the largest legal tens/ones digit of a 00..59 field, and the operating
//   mode enumeration used by stopwatch_core.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX = 4'd9;

  typedef enum logic [1:0] {
    RUN,
    PAUSE,
    ADJUST
  } mode_t;

endpackage

// File: rtl/stopwatch_core_bcd_mod60.sv
// bcd_mod60
//   Two-digit BCD counter covering 00..59 that advances by one on each
//   clock where inc is high, wrapping 59 -> 00.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset, clears both digits
//   inc   in   advance the count by one on this edge
//   tens  out  BCD tens digit (0..5), registered
//   ones  out  BCD ones digit (0..9), registered
//   carry out  combinational: inc is high and the value is 59
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  logic at_max;

  assign at_max = (tens == TENS_MAX) && (ones == ONES_MAX);
  assign carry  = inc && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones == ONES_MAX) begin
        ones <= '0;
        tens <= (tens == TENS_MAX) ? '0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   MM:SS BCD stopwatch driven by divider enable pulses. RUN counts on the
//   1 Hz pulse, PAUSE freezes the count, ADJUST (adj level) advances the
//   selected field on the 2 Hz pulse and blinks it on the 4 Hz pulse.
// Parameters:
//   MINUTE_WRAP  1: 59:59 wraps to 00:00 in RUN; 0: count holds at 59:59
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   one_hz_tick                  RUN counting pulse
//   two_hz_tick                  ADJUST increment pulse
//   four_hz_tick                 blink toggle pulse
//   pause_pulse                  toggles run/pause outside ADJUST
//   adj, sel                     adjust-mode level, field select (1 = min)
//   min_tens..sec_ones           BCD digits, registered
//   blank_min, blank_sec         field blank flags for blinking, registered
//   paused                       count frozen outside ADJUST
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter bit MINUTE_WRAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic one_hz_tick,
  input  logic two_hz_tick,
  input  logic four_hz_tick,
  input  logic pause_pulse,
  input  logic adj,
  input  logic sel,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic blank_min,
  output logic blank_sec,
  output logic paused
);

  mode_t mode;

  logic paused_reg, paused_next;
  logic blink_reg, blink_next;
  logic blank_min_reg, blank_min_next;
  logic blank_sec_reg, blank_sec_next;

  logic sec_inc, min_inc, min_adj_inc;
  logic sec_carry;
  // Minutes rolling past 59 is plain modulo behaviour; nothing consumes it.
  logic unused_min_carry;
  logic at_top;

  bcd_mod60 u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_mod60 u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (unused_min_carry)
  );

  // 59:59 detected straight from the digits so the saturation gate on the
  // seconds increment does not loop back through the counters' carries.
  assign at_top = (sec_tens == TENS_MAX) && (sec_ones == ONES_MAX) &&
                  (min_tens == TENS_MAX) && (min_ones == ONES_MAX);

  // Mode follows the live adj level, so adj rising on the same edge as a
  // 1 Hz pulse already suppresses the RUN increment.
  always_comb begin
    mode = RUN;
    if (adj) begin
      mode = ADJUST;
    end else if (paused_reg) begin
      mode = PAUSE;
    end
  end

  always_comb begin
    sec_inc        = 1'b0;
    min_adj_inc    = 1'b0;
    paused_next    = paused_reg;
    blink_next     = 1'b0;
    blank_min_next = 1'b0;
    blank_sec_next = 1'b0;

    unique case (mode)
      RUN: begin
        if (one_hz_tick && !(!MINUTE_WRAP && at_top)) begin
          sec_inc = 1'b1;
        end
      end
      ADJUST: begin
        if (two_hz_tick) begin
          sec_inc     = !sel;
          min_adj_inc = sel;
        end
      end
      default: ;
    endcase

    if (!adj && pause_pulse) begin
      paused_next = !paused_reg;
    end

    if (adj) begin
      blink_next = blink_reg ^ four_hz_tick;
    end

    blank_min_next = adj && sel && blink_next;
    blank_sec_next = adj && !sel && blink_next;
  end

  // Seconds carry feeds minutes only while counting; in ADJUST the fields
  // are independent.
  assign min_inc = ((mode == RUN) && sec_carry) || min_adj_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused_reg    <= 1'b0;
      blink_reg     <= 1'b0;
      blank_min_reg <= 1'b0;
      blank_sec_reg <= 1'b0;
    end else begin
      paused_reg    <= paused_next;
      blink_reg     <= blink_next;
      blank_min_reg <= blank_min_next;
      blank_sec_reg <= blank_sec_next;
    end
  end

  assign paused    = paused_reg;
  assign blank_min = blank_min_reg;
  assign blank_sec = blank_sec_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core: two instances (wrapping and saturating)
// share one stimulus stream; expected results come from a time-in-seconds
// reference model and are compared by a separate scoreboard monitor.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst;
  logic one_hz_tick, two_hz_tick, four_hz_tick, pause_pulse, adj, sel;

  logic [3:0] min_tens [2];
  logic [3:0] min_ones [2];
  logic [3:0] sec_tens [2];
  logic [3:0] sec_ones [2];
  logic       blank_min [2];
  logic       blank_sec [2];
  logic       paused [2];

  stopwatch_core #(.MINUTE_WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst),
    .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
    .four_hz_tick(four_hz_tick), .pause_pulse(pause_pulse),
    .adj(adj), .sel(sel),
    .min_tens(min_tens[0]), .min_ones(min_ones[0]),
    .sec_tens(sec_tens[0]), .sec_ones(sec_ones[0]),
    .blank_min(blank_min[0]), .blank_sec(blank_sec[0]), .paused(paused[0])
  );

  stopwatch_core #(.MINUTE_WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst),
    .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
    .four_hz_tick(four_hz_tick), .pause_pulse(pause_pulse),
    .adj(adj), .sel(sel),
    .min_tens(min_tens[1]), .min_ones(min_ones[1]),
    .sec_tens(sec_tens[1]), .sec_ones(sec_ones[1]),
    .blank_min(blank_min[1]), .blank_sec(blank_sec[1]), .paused(paused[1])
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][15:0] digits;
    logic [1:0][2:0]  flags;   // {paused, blank_min, blank_sec}
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  // Reference model: each field held as an integer 0..59.
  int m_min [2];
  int m_sec [2];
  bit m_paused;
  bit m_blink;

  function automatic logic [15:0] to_bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_digits(input int k);
    return {min_tens[k], min_ones[k], sec_tens[k], sec_ones[k]};
  endfunction

  function automatic logic [2:0] dut_flags(input int k);
    return {paused[k], blank_min[k], blank_sec[k]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // One clock of stimulus; the model's post-edge state is queued.
  task automatic step(input bit t1, input bit t2, input bit t4, input bit p,
                      input bit a, input bit s);
    exp_t e;
    @(negedge clk);
    one_hz_tick = t1; two_hz_tick = t2; four_hz_tick = t4;
    pause_pulse = p; adj = a; sel = s;
    if (a) begin
      for (int k = 0; k < 2; k++) begin
        if (t2) begin
          if (s) m_min[k] = (m_min[k] + 1) % 60;
          else   m_sec[k] = (m_sec[k] + 1) % 60;
        end
      end
      if (t4) m_blink = !m_blink;
    end else begin
      m_blink = 1'b0;
      if (!m_paused && t1) begin
        for (int k = 0; k < 2; k++) begin
          int t;
          t = m_min[k] * 60 + m_sec[k];
          if (t == 3599) t = (k == 0) ? 0 : 3599;
          else           t = t + 1;
          m_min[k] = t / 60;
          m_sec[k] = t % 60;
        end
      end
      if (p) m_paused = !m_paused;
    end
    for (int k = 0; k < 2; k++) begin
      e.digits[k] = to_bcd(m_min[k], m_sec[k]);
      e.flags[k]  = {m_paused, a && s && m_blink, a && !s && m_blink};
    end
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Waits for the scoreboard to consume the last step, then checks directly.
  task automatic settle_check(input string name, input int k,
                              input logic [15:0] dig, input logic [2:0] flg);
    @(posedge clk);
    #2;
    chk({name, "_digits"}, dut_digits(k), dig);
    chk({name, "_flags"}, {13'd0, dut_flags(k)}, {13'd0, flg});
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    one_hz_tick = 0; two_hz_tick = 0; four_hz_tick = 0;
    pause_pulse = 0; adj = 0; sel = 0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk({name, "_digits"}, dut_digits(k), 16'h0000);
      chk({name, "_flags"}, {13'd0, dut_flags(k)}, 16'h0000);
      m_min[k] = 0;
      m_sec[k] = 0;
    end
    m_paused = 1'b0;
    m_blink  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per clock edge of stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      txn++;
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "wrap_digits" : "sat_digits", dut_digits(k), e.digits[k]);
        chk(k == 0 ? "wrap_flags" : "sat_flags", {13'd0, dut_flags(k)}, {13'd0, e.flags[k]});
      end
      $display("[TB] txn %0d wrap=%h sat=%h flags=%b/%b exp=%h/%h", txn,
               dut_digits(0), dut_digits(1), dut_flags(0), dut_flags(1),
               e.digits[0], e.digits[1]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r_adj, r_sel;
    rst = 1'b1;
    one_hz_tick = 0; two_hz_tick = 0; four_hz_tick = 0;
    pause_pulse = 0; adj = 0; sel = 0;
    #12;
    do_reset("reset_initial");

    // 125 seconds of counting
    repeat (125) step(1, 0, 0, 0, 0, 0);
    settle_check("plan_0205", 0, 16'h0205, 3'b000);

    // Preload 59:58 through ADJUST (1 Hz pulses present but ignored)
    repeat (57) step(1, 1, 0, 0, 1, 1);
    repeat (53) step(1, 1, 0, 0, 1, 0);
    settle_check("preload_5958", 0, 16'h5958, 3'b000);
    idle();
    repeat (3) step(1, 0, 0, 0, 0, 0);
    settle_check("wrap_0001", 0, 16'h0001, 3'b000);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    settle_check("sat_hold", 1, 16'h5959, 3'b000);

    // Pause behaviour
    do_reset("reset_pause");
    repeat (10) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    settle_check("paused_0010", 0, 16'h0010, 3'b100);
    step(1, 0, 0, 1, 0, 0);          // tick ignored, unpauses
    step(1, 0, 0, 0, 0, 0);
    settle_check("resume_0011", 0, 16'h0011, 3'b000);
    step(1, 0, 0, 1, 0, 0);          // increment and pause on one edge
    settle_check("same_edge_pause", 0, 16'h0012, 3'b100);
    step(0, 0, 0, 1, 0, 0);

    // Field adjust without cross-field carry
    repeat (46) step(1, 0, 0, 0, 0, 0);
    settle_check("run_0058", 0, 16'h0058, 3'b000);
    repeat (3) step(1, 1, 0, 0, 1, 0);
    settle_check("adj_sec_wrap", 0, 16'h0001, 3'b000);
    repeat (2) step(1, 1, 0, 0, 1, 1);
    settle_check("adj_min", 0, 16'h0201, 3'b000);

    // Blink on the minutes field, then leave ADJUST
    repeat (3) step(0, 0, 1, 0, 1, 1);
    settle_check("blink_third", 0, 16'h0201, 3'b010);
    step(0, 0, 0, 0, 0, 1);
    settle_check("blink_exit", 0, 16'h0201, 3'b000);

    // 12:34 in ADJUST with the blink phase set, then reset
    repeat (10) step(0, 1, 0, 0, 1, 1);
    repeat (33) step(0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1);
    settle_check("adj_1234", 0, 16'h1234, 3'b010);
    do_reset("reset_mid_adjust");

    // Randomised phase
    r_adj = 0;
    r_sel = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) r_adj = !r_adj;
      if ($urandom_range(0, 7) == 0)  r_sel = !r_sel;
      step($urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           r_adj, r_sel);
    end
    idle();
    @(posedge clk);
    #2;
    chk("queue_drained", 16'(q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
